instruction_fetch: RTL and testbench

- Initiator side of the program-memory read interface.
- Owns the program counter and drives prog_addr into the program memory.
- Captures the returned 32-bit instruction into a registered fetch buffer and hands it to decode over a valid/ready handshake.
- Supports branch redirect/flush and stops fetching on the HALT opcode (7'b1010101).

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 45 ++++
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, the
// HALT opcode, the opcode field position and the fetch FSM state type.
package fetch_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [6:0] HALT_OPCODE = 7'b1010101;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry valid/ready register between program memory and decode.
// Holds one instruction plus the address it came from. Flush drops the
// entry; load overwrites it; a handshake without a load empties it.
module fetch_buffer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] fetch_data,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              ready,
  output logic [DATA_W-1:0] held_data,
  output logic [ADDR_W-1:0] held_pc,
  output logic              valid
);

  logic [DATA_W-1:0] data_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              vld_p1;

  // Stage p0 -> p1: capture memory read data, or drop/consume the held entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p1 <= '0;
      pc_p1   <= '0;
      vld_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      data_p1 <= fetch_data;
      pc_p1   <= fetch_pc;
      vld_p1  <= 1'b1;
    end else if (vld_p1 && ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign held_data = data_p1;
  assign held_pc   = pc_p1;
  assign valid     = vld_p1;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, drives the program-memory address,
// buffers one instruction toward decode and stops on the HALT opcode.
// Branch redirect flushes the buffer and reloads the PC from any state.
// Optional macro INSTRUCTION_FETCH_PERF_EN adds saturating load and stall
// counters (fetch_count, stall_count).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int              ADDR_W      = fetch_pkg::ADDR_W,
  parameter int              DATA_W      = fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [6:0]      HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              halted,
  output logic              busy
`ifdef INSTRUCTION_FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              halt_hit;

  // A load needs FETCH, no pending redirect, and room in the buffer
  assign load     = (state == FETCH) && !redirect_valid && (!inst_valid || inst_ready);
  assign halt_hit = load && (instruction[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

  assign prog_addr = pc;
  assign halted    = (state == HALTED);
  assign busy      = (state == FETCH);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; redirect overrides everything, including start
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = FETCH;
    end else begin
      case (state)
        IDLE:    if (start) state_next = FETCH;
        FETCH:   if (halt_hit) state_next = HALTED;
        HALTED:  state_next = HALTED;
        default: state_next = IDLE;
      endcase
    end
  end

  // Program counter: reload on redirect, step (with wrap) on every load,
  // including the HALT load, so it parks one past the halt word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (load)           pc <= pc + ADDR_W'(1);
  end

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .flush      (redirect_valid),
    .fetch_data (instruction),
    .fetch_pc   (pc),
    .ready      (inst_ready),
    .held_data  (inst_out),
    .held_pc    (inst_pc),
    .valid      (inst_valid)
  );

`ifdef INSTRUCTION_FETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Performance counters, cleared by reset and by start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (start) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (load)                     fetch_count <= sat_inc(fetch_count);
      if (inst_valid && !inst_ready) stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes the expected
// (pc, data) stream; a monitor pops it on every accepted transfer.
module tb_instruction_fetch;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] instruction;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          halted;
  logic          busy;
`ifdef INSTRUCTION_FETCH_PERF_EN
  logic [15:0]   fetch_count;
  logic [15:0]   stall_count;
`endif

  logic [DW-1:0] mem [32];
  exp_t          exp_q [$];
  int            total  = 0;
  int            passed = 0;

  always #5 clk = ~clk;

  assign instruction = mem[prog_addr];

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .prog_addr      (prog_addr),
    .instruction    (instruction),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .halted         (halted),
    .busy           (busy)
`ifdef INSTRUCTION_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a);
    exp_t e;
    e.pc   = AW'(a);
    e.data = mem[a];
    exp_q.push_back(e);
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) push_exp((first + i) % 32);
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
    check("halt_inst_pc", {27'd0, inst_pc}, 32'd8);
    check("halt_prog_addr", {27'd0, prog_addr}, 32'd9);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !inst_valid) break;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    check("no_valid_after_halt", {31'd0, inst_valid}, 32'd0);
    check("pc_parked", {27'd0, prog_addr}, 32'd9);
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", {27'd0, inst_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("xfer_pc", {27'd0, inst_pc}, {27'd0, e.pc});
        check("xfer_data", inst_out, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0013 + (i << 8);
    mem[4] = 32'h0000_0000;
    mem[8] = 32'h0000_0055;

    reset = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_prog_addr", {27'd0, prog_addr}, 32'd0);
    check("rst_inst_out", inst_out, 32'd0);
    check("rst_inst_pc", {27'd0, inst_pc}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, inst_valid}, 32'd0);

    // Start, stream 0..8 with a 3-cycle stall on pc 2, halt on word 8
    tick();
    push_range(0, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_busy_n1", {31'd0, busy}, 32'd1);
    check("start_valid_n1", {31'd0, inst_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("first_valid_n2", {31'd0, inst_valid}, 32'd1);
    check("first_pc_n2", {27'd0, inst_pc}, 32'd0);
    tick();
    tick();
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_pc", {27'd0, inst_pc}, 32'd2);
      check("stall_addr", {27'd0, prog_addr}, 32'd3);
      check("stall_data", inst_out, mem[2]);
      tick();
    end
    inst_ready = 1'b1;
    wait_halted();
    wait_drain();
`ifdef INSTRUCTION_FETCH_PERF_EN
    check("perf_fetch", {16'd0, fetch_count}, 32'd9);
    check("perf_stall", {16'd0, stall_count}, 32'd3);
`endif

    // start is ignored while halted
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_ignored_halted", {31'd0, halted}, 32'd1);
    check("start_ignored_valid", {31'd0, inst_valid}, 32'd0);

    // Redirect out of HALTED to 3
    tick();
    push_range(3, 6);
    redirect_valid = 1'b1; redirect_pc = 5'd3;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid_n1", {31'd0, inst_valid}, 32'd0);
    check("redir_halted_n1", {31'd0, halted}, 32'd0);
    check("redir_busy_n1", {31'd0, busy}, 32'd1);
    check("redir_addr_n1", {27'd0, prog_addr}, 32'd3);
    tick();
    @(negedge clk);
    check("redir_valid_n2", {31'd0, inst_valid}, 32'd1);
    check("redir_pc_n2", {27'd0, inst_pc}, 32'd3);
    wait_halted();
    wait_drain();

    // Redirect to 30 (wrap), then flush a stalled entry with a redirect to 20
    tick();
    push_range(30, 4);
    push_range(20, 21);
    redirect_valid = 1'b1; redirect_pc = 5'd30;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    inst_ready = 1'b0;
    @(negedge clk);
    check("wrap_stall_pc", {27'd0, inst_pc}, 32'd2);
    tick();
    @(negedge clk);
    check("wrap_stall_pc2", {27'd0, inst_pc}, 32'd2);
    tick();
    redirect_valid = 1'b1; redirect_pc = 5'd20;
    tick();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_addr", {27'd0, prog_addr}, 32'd20);
    wait_halted();
    wait_drain();

    // Asynchronous reset in the middle of HALTED
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_halted", {31'd0, halted}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_addr", {27'd0, prog_addr}, 32'd0);
    check("async_rst_pc", {27'd0, inst_pc}, 32'd0);
`ifdef INSTRUCTION_FETCH_PERF_EN
    check("async_rst_fetch_cnt", {16'd0, fetch_count}, 32'd0);
    check("async_rst_stall_cnt", {16'd0, stall_count}, 32'd0);
`endif
    tick();
    reset = 1'b1;
    tick();

    // start and redirect together in IDLE: redirect target wins
    push_range(12, 29);
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd12;
    tick();
    start = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    check("start_redir_busy", {31'd0, busy}, 32'd1);
    check("start_redir_addr", {27'd0, prog_addr}, 32'd12);
    check("start_redir_valid", {31'd0, inst_valid}, 32'd0);
    wait_halted();
    wait_drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    total++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
